// File: rtl/neg_accumulator.sv
// Signed frame accumulator fed by the negator: sums COUNT operands per frame over valid/ready.
// Result one edge after each accept; done pulses the cycle after the last accept; in_ready low outside ACC.
module neg_accumulator #(
  parameter int WIDTH    = 8,
  parameter int COUNT    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           acc,
  output logic                       ovf,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(COUNT+1)-1:0] cnt
);

  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]  sum;
  logic [CW-1:0]     cnt_inc;
  logic              step_ovf;
  logic              accept;

  assign sum      = acc_q + in_data;
  assign cnt_inc  = cnt_q + CW'(1);
  // Same-sign operands whose sum flips sign have left the representable range.
  assign step_ovf = (acc_q[WIDTH-1] == in_data[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
  assign accept   = in_valid && (state_q == ACC);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (step_ovf) begin
            ovf_d = 1'b1;
            if (SATURATE) acc_d = acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
            else          acc_d = sum;
          end else begin
            acc_d = sum;
          end
          if (cnt_inc == CW'(COUNT)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready = (state_q == ACC);
  assign busy     = (state_q == ACC) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign acc      = acc_q;
  assign ovf      = ovf_q;
  assign cnt      = cnt_q;

endmodule
